// File: rtl/alu_a5_driver.sv
// Sequencing front end for the 12-bit signed ALU: loads or repeats one ALU op on an accumulator.
// Optional macro ALU_DRV_FLAGS_EN builds the compare-flag registers behind rsp_gt/rsp_lt/rsp_eq.
module alu_a5_driver #(
  parameter int W  = 12,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ld,
  input  logic [3:0]    cmd_op,
  input  logic [W-1:0]  cmd_b,
  input  logic [CW-1:0] cmd_cnt,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_agrtb,
  input  logic          alu_altb,
  input  logic          alu_aeqb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_gt,
  output logic          rsp_lt,
  output logic          rsp_eq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;

`ifdef ALU_DRV_FLAGS_EN
  // Flag order is {gt, lt, eq}.
  logic [2:0] flags_q, flags_d;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
`ifdef ALU_DRV_FLAGS_EN
    flags_d = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_ld) begin
            acc_d   = cmd_b;
`ifdef ALU_DRV_FLAGS_EN
            flags_d = '0;
`endif
            state_d = RESP;
          end else begin
            b_d     = cmd_b;
            op_d    = cmd_op;
            cnt_d   = cmd_cnt;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        // ALU is combinational: its result for the current acc is written back this edge.
        acc_d = alu_result;
`ifdef ALU_DRV_FLAGS_EN
        flags_d = {alu_agrtb, alu_altb, alu_aeqb};
`endif
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
`ifdef ALU_DRV_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
`ifdef ALU_DRV_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = b_q;
  assign alu_sel   = op_q;

`ifdef ALU_DRV_FLAGS_EN
  assign rsp_gt = flags_q[2];
  assign rsp_lt = flags_q[1];
  assign rsp_eq = flags_q[0];
`else
  logic unused_flags;
  assign unused_flags = alu_agrtb ^ alu_altb ^ alu_aeqb;
  assign rsp_gt = 1'b0;
  assign rsp_lt = 1'b0;
  assign rsp_eq = 1'b0;
`endif

endmodule
